// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder: packs per-field RV32I instruction descriptions into
// 32-bit instruction words, with a small valid/ready output FIFO.
// Optional build macro: ENCODER_ILLEGAL_CHECK_EN. When it is defined, illegal
// field combinations are replaced by a nop and flagged on out_illegal.
module rv32i_instr_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic             out_illegal,
  output logic [CNT_W-1:0] enc_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic [31:0] packed_word;
  logic        bundle_illegal;
  logic [31:0] enc_word;
  logic        is_shift;

  logic [31:0]      mem_word_q [DEPTH];
  logic             mem_ill_q  [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] enc_count_q, enc_count_d;
  logic             full, empty, push, pop;

  assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  // Field packing by instruction format; unknown opcodes fall back to R layout.
  always_comb begin
    packed_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
    case (in_opcode)
      OP_IMM: begin
        if (is_shift)
          packed_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
        else
          packed_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      OP_LOAD, OP_JALR:
        packed_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      OP_STORE:
        packed_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      OP_BR:
        packed_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], in_opcode};
      OP_LUI, OP_AUIPC:
        packed_word = {in_imm[31:12], in_rd, in_opcode};
      OP_JAL:
        packed_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      default: ;
    endcase
  end

`ifdef ENCODER_ILLEGAL_CHECK_EN
  logic sx12, sx13, sx21;
  // Immediate must be the sign extension of its encodable field width.
  assign sx12 = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
  assign sx13 = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
  assign sx21 = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);

  // Legality screen of the offered field combination.
  always_comb begin
    bundle_illegal = 1'b0;
    case (in_opcode)
      OP_REG: begin
        if ((in_funct7 != F7_BASE) && (in_funct7 != F7_ALT))
          bundle_illegal = 1'b1;
        else if ((in_funct7 == F7_ALT) && (in_funct3 != 3'b000) && (in_funct3 != 3'b101))
          bundle_illegal = 1'b1;
      end
      OP_IMM: begin
        if (is_shift) begin
          // shamt is an unsigned 5-bit amount
          if ((in_funct7 != F7_BASE) && !((in_funct7 == F7_ALT) && (in_funct3 == 3'b101)))
            bundle_illegal = 1'b1;
          if (in_imm[31:5] != '0)
            bundle_illegal = 1'b1;
        end else if (!sx12) begin
          bundle_illegal = 1'b1;
        end
      end
      OP_LOAD: begin
        if ((in_funct3 == 3'b011) || (in_funct3 == 3'b110) || (in_funct3 == 3'b111) || !sx12)
          bundle_illegal = 1'b1;
      end
      OP_STORE: begin
        if ((in_funct3 > 3'b010) || !sx12)
          bundle_illegal = 1'b1;
      end
      OP_BR: begin
        if ((in_funct3 == 3'b010) || (in_funct3 == 3'b011) || in_imm[0] || !sx13)
          bundle_illegal = 1'b1;
      end
      OP_JALR: begin
        if ((in_funct3 != 3'b000) || !sx12)
          bundle_illegal = 1'b1;
      end
      OP_JAL: begin
        if (in_imm[0] || !sx21)
          bundle_illegal = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        if (in_imm[11:0] != '0)
          bundle_illegal = 1'b1;
      end
      default: bundle_illegal = 1'b1;
    endcase
  end
`else
  assign bundle_illegal = 1'b0;
`endif

  assign enc_word = bundle_illegal ? NOP_WORD : packed_word;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign push  = in_valid && !full;
  assign pop   = !empty && out_ready;

  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign out_word    = empty ? 32'h0 : mem_word_q[rd_ptr_q];
  assign out_illegal = empty ? 1'b0 : mem_ill_q[rd_ptr_q];
  assign enc_count   = enc_count_q;

  // Next-state for FIFO pointers, occupancy and delivered-word counter.
  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d       = cnt_q;
    if (push && !pop)
      cnt_d = cnt_q + (PTR_W + 1)'(1);
    else if (pop && !push)
      cnt_d = cnt_q - (PTR_W + 1)'(1);
    enc_count_d = enc_count_q + CNT_W'(pop);
  end

  // FIFO storage and control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      enc_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_word_q[i] <= '0;
        mem_ill_q[i]  <= 1'b0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      enc_count_q <= enc_count_d;
      if (push) begin
        mem_word_q[wr_ptr_q] <= enc_word;
        mem_ill_q[wr_ptr_q]  <= bundle_illegal;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Testbench for rv32i_instr_encoder: directed cases followed by random
// bundles, checked against a queue-based reference model.
module tb_rv32i_instr_encoder;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       in_opcode;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [4:0]       in_rd, in_rs1, in_rs2;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_word;
  logic             out_illegal;
  logic [CNT_W-1:0] enc_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] w;
    logic        ill;
  } ent_t;

  ent_t             q[$];
  logic [CNT_W-1:0] exp_cnt;
  logic             last_acc;

  always #5 clk = ~clk;

  rv32i_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_illegal(out_illegal), .enc_count(enc_count)
  );

  function automatic int unsigned fld(input int unsigned v, input int lo, input int n);
    return (v >> lo) & ((32'd1 << n) - 32'd1);
  endfunction

  // Reference encoder: builds the word by weighted field placement.
  function automatic logic [31:0] model_enc(input int unsigned op, input int unsigned f3,
                                            input int unsigned f7, input int unsigned rd,
                                            input int unsigned rs1, input int unsigned rs2,
                                            input int unsigned imm);
    int unsigned w;
    w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
    case (op)
      'h13: begin
        if (f3 == 1 || f3 == 5)
          w = (f7 << 25) | (fld(imm, 0, 5) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        else
          w = (fld(imm, 0, 12) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      end
      'h03, 'h67:
        w = (fld(imm, 0, 12) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      'h23:
        w = (fld(imm, 5, 7) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
          | (fld(imm, 0, 5) << 7) | op;
      'h63:
        w = (fld(imm, 12, 1) << 31) | (fld(imm, 5, 6) << 25) | (rs2 << 20) | (rs1 << 15)
          | (f3 << 12) | (fld(imm, 1, 4) << 8) | (fld(imm, 11, 1) << 7) | op;
      'h37, 'h17:
        w = (fld(imm, 12, 20) << 12) | (rd << 7) | op;
      'h6f:
        w = (fld(imm, 20, 1) << 31) | (fld(imm, 1, 10) << 21) | (fld(imm, 11, 1) << 20)
          | (fld(imm, 12, 8) << 12) | (rd << 7) | op;
      default: ;
    endcase
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    check("enc_count", 32'(enc_count), 32'(exp_cnt));
    if (q.size() > 0) begin
      check("out_word", out_word, q[0].w);
      check("out_illegal", 32'(out_illegal), 32'(q[0].ill));
    end
  endtask

  // One clock cycle: drive a bundle, advance, update the model, check outputs.
  task automatic cyc(input logic v, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm, input logic ordy,
                     input logic ill);
    logic acc, pp;
    ent_t e;
    in_valid = v; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; out_ready = ordy;
    acc = v && (q.size() < DEPTH);
    pp  = (q.size() > 0) && ordy;
    @(posedge clk); #1;
    if (pp) begin
      q.delete(0);
      exp_cnt = exp_cnt + 1'b1;
    end
    if (acc) begin
      e.w   = ill ? 32'h0000_0013 : model_enc(op, f3, f7, rd, rs1, rs2, imm);
      e.ill = ill;
      q.push_back(e);
    end
    last_acc = acc;
    check_state();
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, ordy, 1'b0);
  endtask

  task automatic addi(input logic [4:0] rd, input logic [31:0] imm, input logic ordy);
    cyc(1'b1, 7'h13, 3'd0, 7'd0, rd, 5'd0, 5'd0, imm, ordy, 1'b0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    #1;
    q.delete();
    exp_cnt = '0;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_word", out_word, 32'd0);
    check("rst out_illegal", 32'(out_illegal), 32'd0);
    check("rst enc_count", 32'(enc_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [6:0]  rop;
    logic [31:0] rimm;
    int          guard;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    exp_cnt = '0; last_acc = 1'b0;
    #2;
    do_reset();

    // addi x1,x0,5: word visible the cycle after acceptance
    addi(5'd1, 32'd5, 1'b1);
    check("addi word", out_word, 32'h0050_0093);
    check("addi valid", 32'(out_valid), 32'd1);
    idle(1'b1);

    // sub x3,x1,x2
    cyc(1'b1, 7'h33, 3'd0, 7'b0100000, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b0);
    check("sub word", out_word, 32'h4020_81B3);
    idle(1'b1);

    // beq x1,x2,-8 then jal x1,2048 (rs2 on jal must not leak into the word)
    cyc(1'b1, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 1'b0, 1'b0);
    check("beq word", out_word, 32'hFE20_8CE3);
    cyc(1'b1, 7'h6f, 3'd5, 7'h7f, 5'd1, 5'd9, 5'd31, 32'd2048, 1'b1, 1'b0);
    check("jal word", out_word, 32'h0010_00EF);
    idle(1'b1);

    // Reset mid-stream: fill FIFO, assert rst between edges
    addi(5'd4, 32'd1, 1'b0);
    addi(5'd5, 32'd2, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst enc_count", 32'(enc_count), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd1);
    do_reset();

    // Backpressure: third bundle refused until a word leaves
    addi(5'd6, 32'd10, 1'b0);
    addi(5'd7, 32'd11, 1'b0);
    check("bp in_ready", 32'(in_ready), 32'd0);
    addi(5'd8, 32'd12, 1'b0);
    check("bp third refused", 32'(last_acc), 32'd0);
    guard = 0;
    last_acc = 1'b0;
    while (!last_acc && guard < 10) begin
      addi(5'd8, 32'd12, 1'b1);
      guard++;
    end
    check("bp third accepted", 32'(last_acc), 32'd1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    check("bp enc_count", 32'(enc_count), 32'd3);

    // Full FIFO with pop and offer in the same cycle: pop only, push next cycle
    addi(5'd9, 32'd20, 1'b0);
    addi(5'd10, 32'd21, 1'b0);
    addi(5'd11, 32'd22, 1'b1);
    check("full no push", 32'(last_acc), 32'd0);
    check("full popped", 32'(in_ready), 32'd1);
    addi(5'd11, 32'd22, 1'b0);
    check("push after pop", 32'(last_acc), 32'd1);
    for (int i = 0; i < 3; i++) idle(1'b1);

`ifdef ENCODER_ILLEGAL_CHECK_EN
    // lw with funct3=011 becomes a flagged nop and still counts
    cyc(1'b1, 7'h03, 3'b011, 7'd0, 5'd1, 5'd2, 5'd0, 32'd4, 1'b0, 1'b1);
    check("illegal flag", 32'(out_illegal), 32'd1);
    check("illegal word", out_word, 32'h0000_0013);
    idle(1'b1);
    idle(1'b1);
`else
    // Random bundles with random backpressure
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0: rop = 7'h33;
        1: rop = 7'h13;
        2: rop = 7'h03;
        3: rop = 7'h67;
        4: rop = 7'h23;
        5: rop = 7'h63;
        6: rop = 7'h37;
        7: rop = 7'h17;
        8: rop = 7'h6f;
        default: rop = 7'($urandom);
      endcase
      rimm = $urandom;
      cyc(1'($urandom_range(0, 3) != 0), rop, 3'($urandom), 7'($urandom),
          5'($urandom), 5'($urandom), 5'($urandom), rimm,
          1'($urandom_range(0, 2) != 0), 1'b0);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    check("final drained", 32'(out_valid), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
